// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: picks sequential, branch, stall, exception-vector or ERET target each cycle.
// One-cycle redirect latency; en_f drops while D stalls or an ERET waits on a pending EPC write.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        stall_d,
  input  logic        eret_d,
  input  logic        epc_wr_pending,
  input  logic [31:0] epc,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        en_f,
  output logic        flush_fd,
  output logic        flush_all,
  output logic        adel_f,
  output logic        in_handler,
  output logic        state
);

  typedef enum logic {
    RUN       = 1'b0,
    ERET_WAIT = 1'b1
  } state_t;

  state_t      st_q, st_nx;
  logic [31:0] pc_q, pc_nx;
  logic        in_handler_q, in_handler_nx;
  logic        eret_blocked;

  // ERET may not read EPC while an mtc0 to it is still in flight, nor while D is frozen.
  assign eret_blocked = epc_wr_pending | stall_d;

  always_comb begin
    st_nx         = st_q;
    pc_nx         = pc_q;
    in_handler_nx = in_handler_q;
    en_f          = 1'b0;
    flush_fd      = 1'b0;
    flush_all     = 1'b0;
    if (reset) begin
      st_nx = RUN;
    end else if (req) begin
      pc_nx         = EXC_VECTOR;
      in_handler_nx = 1'b1;
      st_nx         = RUN;
      en_f          = 1'b1;
      flush_all     = 1'b1;
    end else begin
      case (st_q)
        RUN: begin
          if (eret_d) begin
            if (eret_blocked) begin
              st_nx = ERET_WAIT;
            end else begin
              pc_nx         = epc;
              in_handler_nx = 1'b0;
              en_f          = 1'b1;
              flush_fd      = 1'b1;
            end
          end else if (!stall_d) begin
            en_f  = 1'b1;
            pc_nx = (br_valid && br_taken) ? br_target : pc_q + 32'd4;
          end
        end
        ERET_WAIT: begin
          // A withdrawn ERET returns to RUN with the PC parked for one cycle.
          if (!eret_d) begin
            st_nx = RUN;
          end else if (!eret_blocked) begin
            pc_nx         = epc;
            in_handler_nx = 1'b0;
            st_nx         = RUN;
            en_f          = 1'b1;
            flush_fd      = 1'b1;
          end
        end
        default: st_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= RUN;
      pc_q         <= RESET_PC;
      in_handler_q <= 1'b0;
    end else begin
      st_q         <= st_nx;
      pc_q         <= pc_nx;
      in_handler_q <= in_handler_nx;
    end
  end

  assign pc         = pc_q;
  assign pc_plus8   = pc_q + 32'd8;
  assign in_handler = in_handler_q;
  assign state      = st_q;
  assign adel_f     = (pc_q[1:0] != 2'b00) | (pc_q < TEXT_LO) | (pc_q > TEXT_HI);

endmodule
